// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types for the FP multiplier result path.
//   status_t  : 5-bit IEEE status vector {NV,DZ,OF,UF,NX}
//   ST_*      : bit positions inside status_t
//   entry_t   : {res,status,tag} queue entry at the default 32-bit / 4-bit-tag
//               widths (parameterised blocks build the same layout locally)
//   ptr_w()   : pointer width for an N-entry memory, at least 1 bit
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int STATUS_W = 5;

  typedef logic [STATUS_W-1:0] status_t;

  localparam int ST_NV = 4;
  localparam int ST_DZ = 3;
  localparam int ST_OF = 2;
  localparam int ST_UF = 1;
  localparam int ST_NX = 0;

  localparam int DEF_EXPO_W = 8;
  localparam int DEF_MANT_W = 23;
  localparam int DEF_TAG_W  = 4;

  typedef struct packed {
    logic [DEF_EXPO_W+DEF_MANT_W:0] res;
    status_t                        status;
    logic [DEF_TAG_W-1:0]           tag;
  } entry_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// -----------------------------------------------------------------------------
// fp_sync_fifo
// First-word-fall-through synchronous FIFO, any DEPTH >= 1.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write when push and (not full, or a pop happens the same edge)
//   pop        : remove head when not empty (pop on empty is ignored)
//   rdata      : current head; while empty it holds the last popped entry
//                (zero after reset)
//   full/empty/count : occupancy
// -----------------------------------------------------------------------------
module fp_sync_fifo
  import fp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot the write lands in; the head
  // has already been copied into hold_reg on that same edge.
  assign do_push = push & (~full | do_pop);
  assign count   = count_reg;
  assign rdata   = empty ? hold_reg : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
        hold_reg   <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_result_queue.sv
// -----------------------------------------------------------------------------
// fp_mul_result_queue
// Sits behind a fixed-latency, handshake-free FP multiplier. Issues credits to
// the operand source, tracks ops in flight, captures res/status LAT edges after
// issue and queues them in order behind a valid/ready output. Sticky IEEE
// flags accumulate on retirement when FP_MUL_RQ_STICKY_FLAGS_EN is defined;
// otherwise flags_o is tied to zero and flags_clr is ignored.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : op issued to the multiplier when both high
//   req_tag               : tag travelling with the issued op
//   mul_res/mul_status    : multiplier outputs, sampled LAT edges after issue
//   out_valid/out_ready   : queue head handshake
//   out_res/out_status/out_tag : queue head (held when out_valid is low)
//   flags_clr, flags_o    : sticky flag clear / sticky OR of retired statuses
//   inflight_o            : ops issued and not yet captured
// -----------------------------------------------------------------------------
module fp_mul_result_queue
  import fp_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LAT    = 3,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TAG_W-1:0]              req_tag,
  input  logic [EXPO_W+MANT_W:0]        mul_res,
  input  logic [4:0]                    mul_status,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXPO_W+MANT_W:0]        out_res,
  output logic [4:0]                    out_status,
  output logic [TAG_W-1:0]              out_tag,
  input  logic                          flags_clr,
  output logic [4:0]                    flags_o,
  output logic [$clog2(LAT+1)-1:0]      inflight_o
);

  localparam int DATA_W = 1 + EXPO_W + MANT_W;
  localparam int IW     = $clog2(LAT+1);
  localparam int CW     = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    status_t           status;
    logic [TAG_W-1:0]  tag;
  } q_entry_t;

  localparam int EW = $bits(q_entry_t);

  logic             fire, capture, pop;
  logic [LAT-1:0]   vld_pipe_reg;
  logic [TAG_W-1:0] tag_pipe_reg [LAT];
  logic [IW-1:0]    inflight_reg;
  q_entry_t         push_entry, head_entry;
  logic [EW-1:0]    head_bits;
  logic             q_empty;
  logic             unused_q_full;
  logic [CW-1:0]    q_count;

  // Credits count both slots already holding results and slots reserved by
  // ops still inside the multiplier, so a capture can never find the queue
  // full. Only registered terms feed req_ready.
  assign req_ready = (32'(inflight_reg) + 32'(q_count)) < 32'(DEPTH);
  assign fire      = req_valid & req_ready;
  assign capture   = vld_pipe_reg[LAT-1];
  assign out_valid = ~q_empty;
  assign pop       = out_valid & out_ready;

  // Marker pipe: stage LAT-1 is set exactly when the multiplier presents the
  // result of the op issued LAT edges earlier. Reset clears it, so results of
  // ops issued before reset are never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_reg <= '0;
      for (int i = 0; i < LAT; i++) tag_pipe_reg[i] <= '0;
    end else begin
      vld_pipe_reg[0] <= fire;
      tag_pipe_reg[0] <= req_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe_reg[i] <= vld_pipe_reg[i-1];
        tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else begin
      case ({fire, capture})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  assign inflight_o = inflight_reg;

  always_comb begin
    push_entry        = '0;
    push_entry.res    = mul_res;
    push_entry.status = mul_status;
    push_entry.tag    = tag_pipe_reg[LAT-1];
  end

  fp_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_bits),
    .full  (unused_q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign head_entry = q_entry_t'(head_bits);
  assign out_res    = head_entry.res;
  assign out_status = head_entry.status;
  assign out_tag    = head_entry.tag;

`ifdef FP_MUL_RQ_STICKY_FLAGS_EN
  status_t flags_reg, flags_next;

  // Flags follow retirement: the popped status is ORed in even when a clear
  // arrives on the same edge.
  always_comb begin
    flags_next = flags_clr ? '0 : flags_reg;
    if (pop) flags_next = flags_next | head_entry.status;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_reg <= '0;
    else        flags_reg <= flags_next;
  end

  assign flags_o = flags_reg;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign flags_o          = '0;
`endif

endmodule
